crack_scheduler: RTL
====================

Name: crack_scheduler

Overview:
Job scheduler for a pool of key-search engines. It splits the key space into TOTAL_SLICES slices and hands them to N_ENG shared engines, lowest free engine first. It tracks completions, captures the first cracked key, and aborts the pool on a hit. It sits between the top-level start/rdy/result interface and the engine array, replacing one hard-wired engine per slice.

Parameters:
N_ENG, 4, number of engines in the pool (1..16)
TOTAL_SLICES, 29, number of key-space slices to search
SLICE_W, 5, slice index width; must satisfy 2^SLICE_W > TOTAL_SLICES
KEY_W, 128, cracked key width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
start  in  1  begin a search; sampled in IDLE or DONE only
rdy  out  1  search finished; held high in DONE until the next start
found  out  1  valid while rdy; 1 = key cracked
result  out  KEY_W  cracked key; 0 if not found
eng_start  out  N_ENG  one-hot, one-cycle dispatch pulse per engine
eng_slice  out  SLICE_W  slice index; valid only while eng_start is nonzero
eng_abort  out  1  one-cycle pulse that kills all engines
eng_done  in  N_ENG  per-engine one-cycle completion pulse
eng_found  in  N_ENG  per-engine hit flag, qualified by eng_done
eng_key  in  N_ENG*KEY_W  engine i key at bits [i*KEY_W +: KEY_W], qualified by eng_done&eng_found
slices_done  out  SLICE_W+1  count of slices completed in the current search

Behaviour:
- Interface: one clock (clk); rst is synchronous and active-high.
- All outputs are registered.
- Reset: state IDLE. rdy, found, result, eng_start, eng_slice, eng_abort and slices_done are all 0. The busy mask and next_slice are cleared.
- Reset mid-search: same as above on the next edge. No eng_abort pulse is issued, because engines share rst.
- States: IDLE, RUN, ABORT, DONE.
- IDLE/DONE with start=1:
  - Clear next_slice, slices_done, busy, found, result and rdy.
  - Go to RUN.
- start is ignored in RUN and ABORT.
- RUN, per cycle, in this order:
  1. Completion: every engine i with eng_done[i]=1 and busy[i]=1 clears busy[i]. slices_done increases by the popcount of those engines. eng_done from an engine that is not busy is ignored.
  2. Hit: if any qualified done has eng_found=1, take the lowest such index i. Latch found=1 and result=eng_key[i], pulse eng_abort next cycle, go to ABORT. No dispatch happens in this cycle.
  3. Dispatch: if there is no hit, next_slice < TOTAL_SLICES, and some engine has registered busy=0, pick the lowest such engine j. Drive eng_start[j]=1 and eng_slice=next_slice for one cycle, set busy[j], and increment next_slice. An engine freed in the current cycle becomes eligible next cycle. At most one dispatch per cycle.
  4. Exhaustion: if there is no hit and slices_done (after the update) == TOTAL_SLICES, go to DONE with found=0 and result=0.
- ABORT: eng_abort is high for exactly this one cycle, busy is cleared, eng_done is ignored, and the next state is DONE.
- DONE: rdy=1; found, result and slices_done are held.
- Latency:
  - The first eng_start pulse is visible one cycle after RUN is entered.
  - A hit at edge m gives found/result/eng_abort after edge m and rdy after edge m+1.
  - Exhaustion at edge m gives rdy after edge m.
- Slices are dispatched in strictly ascending order 0..TOTAL_SLICES-1, each exactly once per search.
- TOTAL_SLICES < N_ENG is legal: the surplus engines are never started.

Test Plan:
1. Reset: hold rst 3 cycles -> all outputs 0 and state IDLE; start pulses during rst are ignored.
2. Full miss (N_ENG=4, TOTAL_SLICES=29, each engine pulses eng_done found=0 three cycles after its eng_start) -> 29 eng_start pulses carrying slices 0..28 in order with no slice repeated; rdy=1, found=0, result=0, slices_done=29.
3. Hit on slice 17 (key 0x0123_4567_89AB_CDEF_FEDC_BA98_7654_3210) -> found=1 and result=that key; eng_abort high exactly one cycle; no eng_start after the hit cycle; rdy one cycle later.
4. Same-cycle hits on engines 1 and 3 with different keys -> result = engine 1 key; only one eng_abort pulse.
5. Spurious eng_done on an idle engine, and eng_done asserted during ABORT -> slices_done unchanged, no state change.
6. rst asserted mid-RUN after 10 dispatches, then start -> clean restart from slice 0; slices_done restarts at 0 and the search completes normally.

Source files
------------

// File: rtl/crack_scheduler.sv
// crack_scheduler: hands key-space slices to a shared pool of search engines,
// lowest free engine first, counts completions and stops the pool on the
// first cracked key.

// Per-engine qualifier: a done pulse only counts while the engine is busy.
module crack_scheduler_lane (
    input  logic busy,
    input  logic done,
    input  logic found,
    output logic qual_done,
    output logic qual_hit
);
    assign qual_done = done & busy;
    assign qual_hit  = qual_done & found;
endmodule

module crack_scheduler #(
    parameter int N_ENG        = 4,
    parameter int TOTAL_SLICES = 29,
    parameter int SLICE_W      = 5,
    parameter int KEY_W        = 128
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   rdy,
    output logic                   found,
    output logic [KEY_W-1:0]       result,
    output logic [N_ENG-1:0]       eng_start,
    output logic [SLICE_W-1:0]     eng_slice,
    output logic                   eng_abort,
    input  logic [N_ENG-1:0]       eng_done,
    input  logic [N_ENG-1:0]       eng_found,
    input  logic [N_ENG*KEY_W-1:0] eng_key,
    output logic [SLICE_W:0]       slices_done
);
    localparam int CNT_W = SLICE_W + 1;
    // next_slice tops out at TOTAL_SLICES, which fits in SLICE_W bits.
    localparam logic [SLICE_W-1:0] TOTAL_S   = SLICE_W'(TOTAL_SLICES);
    localparam logic [CNT_W-1:0]   TOTAL_CNT = CNT_W'(TOTAL_SLICES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ABORT,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [N_ENG-1:0]     busy_q, busy_d;
    logic [SLICE_W-1:0]   next_slice_q, next_slice_d;
    logic [CNT_W-1:0]     slices_done_q, slices_done_d;
    logic                 found_q, found_d;
    logic [KEY_W-1:0]     result_q, result_d;
    logic                 rdy_q, rdy_d;
    logic [N_ENG-1:0]     eng_start_q, eng_start_d;
    logic [SLICE_W-1:0]   eng_slice_q, eng_slice_d;
    logic                 eng_abort_q, eng_abort_d;

    logic [N_ENG-1:0]     qual_done;
    logic [N_ENG-1:0]     qual_hit;
    logic [CNT_W-1:0]     done_cnt;
    logic [CNT_W-1:0]     done_sum;
    logic                 hit_any;
    logic [KEY_W-1:0]     hit_key;
    logic                 free_any;
    logic [N_ENG-1:0]     free_oh;

    for (genvar g = 0; g < N_ENG; g++) begin : g_lane
        crack_scheduler_lane u_lane (
            .busy      (busy_q[g]),
            .done      (eng_done[g]),
            .found     (eng_found[g]),
            .qual_done (qual_done[g]),
            .qual_hit  (qual_hit[g])
        );
    end

    // Completion popcount, lowest-index hit key and lowest free engine.
    // Descending scan so the lowest index is the last one written.
    always_comb begin
        done_cnt = '0;
        hit_any  = 1'b0;
        hit_key  = '0;
        free_any = 1'b0;
        free_oh  = '0;
        for (int i = N_ENG - 1; i >= 0; i--) begin
            done_cnt = done_cnt + CNT_W'(qual_done[i]);
            if (qual_hit[i]) begin
                hit_any = 1'b1;
                hit_key = eng_key[i*KEY_W +: KEY_W];
            end
            // Eligibility uses the registered busy mask, so an engine freed
            // this cycle is only reused from the next cycle on.
            if (!busy_q[i]) begin
                free_any   = 1'b1;
                free_oh    = '0;
                free_oh[i] = 1'b1;
            end
        end
    end

    // Next-state and registered-output logic for the search FSM.
    always_comb begin
        state_d       = state_q;
        busy_d        = busy_q;
        next_slice_d  = next_slice_q;
        slices_done_d = slices_done_q;
        found_d       = found_q;
        result_d      = result_q;
        rdy_d         = rdy_q;
        eng_start_d   = '0;
        eng_slice_d   = '0;
        eng_abort_d   = 1'b0;
        done_sum      = slices_done_q + done_cnt;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    next_slice_d  = '0;
                    slices_done_d = '0;
                    busy_d        = '0;
                    found_d       = 1'b0;
                    result_d      = '0;
                    rdy_d         = 1'b0;
                    state_d       = S_RUN;
                end
            end
            S_RUN: begin
                busy_d        = busy_q & ~qual_done;
                slices_done_d = done_sum;
                if (hit_any) begin
                    // A hit suppresses dispatch and kills the pool next cycle.
                    found_d     = 1'b1;
                    result_d    = hit_key;
                    eng_abort_d = 1'b1;
                    state_d     = S_ABORT;
                end else begin
                    if (next_slice_q < TOTAL_S && free_any) begin
                        eng_start_d  = free_oh;
                        eng_slice_d  = next_slice_q;
                        busy_d       = busy_d | free_oh;
                        next_slice_d = next_slice_q + SLICE_W'(1);
                    end
                    if (done_sum == TOTAL_CNT) begin
                        found_d  = 1'b0;
                        result_d = '0;
                        rdy_d    = 1'b1;
                        state_d  = S_DONE;
                    end
                end
            end
            S_ABORT: begin
                // Completions racing the abort are dropped on purpose.
                busy_d  = '0;
                rdy_d   = 1'b1;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            busy_q        <= '0;
            next_slice_q  <= '0;
            slices_done_q <= '0;
            found_q       <= 1'b0;
            result_q      <= '0;
            rdy_q         <= 1'b0;
            eng_start_q   <= '0;
            eng_slice_q   <= '0;
            eng_abort_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            next_slice_q  <= next_slice_d;
            slices_done_q <= slices_done_d;
            found_q       <= found_d;
            result_q      <= result_d;
            rdy_q         <= rdy_d;
            eng_start_q   <= eng_start_d;
            eng_slice_q   <= eng_slice_d;
            eng_abort_q   <= eng_abort_d;
        end
    end

    assign rdy         = rdy_q;
    assign found       = found_q;
    assign result      = result_q;
    assign eng_start   = eng_start_q;
    assign eng_slice   = eng_slice_q;
    assign eng_abort   = eng_abort_q;
    assign slices_done = slices_done_q;
endmodule
